ckpt_data_que: RTL

CKPT_DATA_QUE -- requirements
Module: ckpt_data_que

---
 rtl/ckpt_data_que_pkg.sv | 34 +++
 rtl/ckpt_data_que_circ_ptr_add.sv | 26 ++
 rtl/ckpt_data_que.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ckpt_data_que_pkg.sv
// Shared definitions for the checkpoint data queue: index width helper,
// squash request bundle and the popcount used for lane/release counting.
// Pure declarations; no logic, no latency, no flow control.
`ifndef XDEF
`define XDEF 63:0
`endif

package ckpt_data_que_pkg;

    localparam int MAX_IDX_W = 16;

    // Index width for a DEPTH-entry queue; never below one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Rollback request as seen by the queue: all=1 discards everything,
    // otherwise idx names the youngest surviving entry.
    typedef struct packed {
        logic                 vld;
        logic                 all;
        logic [MAX_IDX_W-1:0] idx;
    } squash_req_t;

    function automatic logic [7:0] count_one(input logic [63:0] vec);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {7'd0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ckpt_data_que_circ_ptr_add.sv
// Circular pointer add: o_sum = (i_ptr + i_off) mod DEPTH for any DEPTH.
// Combinational, zero latency.
// No flow control; caller guarantees i_ptr < DEPTH and i_off <= DEPTH.
// Ports: i_ptr (slot index), i_off (offset, one bit wider), o_sum (slot index).
module circ_ptr_add #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [IDX_W:0]   i_off,
    output logic [IDX_W-1:0] o_sum
);

    localparam logic [IDX_W+1:0] DEPTH_W = (IDX_W+2)'(DEPTH);

    logic [IDX_W+1:0] raw;
    logic [IDX_W+1:0] wrapped;

    // Operands are bounded so a single conditional subtract is enough.
    always_comb begin
        raw     = {2'b00, i_ptr} + {1'b0, i_off};
        wrapped = (raw >= DEPTH_W) ? (raw - DEPTH_W) : raw;
        o_sum   = IDX_W'(wrapped);
    end

endmodule

// File: rtl/ckpt_data_que.sv
// Checkpoint data queue: age-ordered circular buffer with multi-lane enqueue,
// combinational reads, writeback done-marking, in-order release and squash.
// Enqueue results visible next cycle; reads combinational; releases take effect next cycle.
// Enqueue is all-or-nothing, gated by o_can_enq (>= INPORT_NUM free) and blocked by squash.
// Ports: clk/rst (async active-low); enqueue (i_enq_req/i_enq_data -> o_alloc_id, o_can_enq);
//        read (i_read_dqIdx -> o_read_data); writeback (i_wb_vld/i_wb_dqIdx);
//        squash (i_squash_vld/i_squash_all/i_squash_dqIdx); o_free_num.
`ifndef XDEF
`define XDEF 63:0
`endif

module ckpt_data_que
    import ckpt_data_que_pkg::*;
#(
    parameter int  DEPTH        = 32,
    parameter int  INPORT_NUM   = 4,
    parameter int  READPORT_NUM = 4,
    parameter int  WBPORT_NUM   = 4,
    parameter int  CLEAR_WID    = 4,
    parameter type dtype        = logic [`XDEF],
    localparam int IDX_W        = idx_width(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 o_can_enq,
    input  logic [INPORT_NUM-1:0]                i_enq_req,
    input  dtype                                 i_enq_data [INPORT_NUM],
    output logic [INPORT_NUM-1:0][IDX_W-1:0]     o_alloc_id,
    input  logic [READPORT_NUM-1:0][IDX_W-1:0]   i_read_dqIdx,
    output dtype                                 o_read_data [READPORT_NUM],
    input  logic [WBPORT_NUM-1:0]                i_wb_vld,
    input  logic [WBPORT_NUM-1:0][IDX_W-1:0]     i_wb_dqIdx,
    input  logic                                 i_squash_vld,
    input  logic                                 i_squash_all,
    input  logic [IDX_W-1:0]                     i_squash_dqIdx,
    output logic [CNT_W-1:0]                     o_free_num
);

    localparam logic [IDX_W:0]   DEPTH_X = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    dtype             mem_q [DEPTH];

    squash_req_t      sq;
    logic [IDX_W-1:0] sq_idx;

    assign sq     = '{vld: i_squash_vld, all: i_squash_all, idx: MAX_IDX_W'(i_squash_dqIdx)};
    assign sq_idx = IDX_W'(sq.idx);

    // Age of a slot relative to the head (0 = oldest).
    function automatic logic [IDX_W:0] age_of(input logic [IDX_W-1:0] slot,
                                              input logic [IDX_W-1:0] hd);
        return (slot >= hd) ? ({1'b0, slot} - {1'b0, hd})
                            : ({1'b0, slot} + DEPTH_X - {1'b0, hd});
    endfunction

    // ---------------- enqueue lanes ----------------
    logic [INPORT_NUM-1:0]             below;
    logic [INPORT_NUM-1:0][IDX_W:0]    lane_off;
    logic [INPORT_NUM-1:0][IDX_W-1:0]  lane_id;
    logic [CNT_W-1:0]                  enq_num;
    logic                              enq_fire;

    // A lane's slot offset is the number of requesting lanes below it.
    always_comb begin
        below    = '0;
        lane_off = '0;
        for (int i = 0; i < INPORT_NUM; i++) begin
            below = '0;
            for (int j = 0; j < i; j++) begin
                below[j] = i_enq_req[j];
            end
            lane_off[i] = (IDX_W+1)'(count_one(64'(below)));
        end
    end

    for (genvar i = 0; i < INPORT_NUM; i++) begin : g_tail_lane
        circ_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_tail_add (
            .i_ptr (tail_q),
            .i_off (lane_off[i]),
            .o_sum (lane_id[i])
        );
        assign o_alloc_id[i] = i_enq_req[i] ? lane_id[i] : '0;
    end

    assign o_free_num = DEPTH_C - count_q;
    assign o_can_enq  = (o_free_num >= CNT_W'(INPORT_NUM));
    assign enq_num    = CNT_W'(count_one(64'(i_enq_req)));
    assign enq_fire   = o_can_enq & (|i_enq_req) & ~sq.vld;

    // ---------------- in-order release ----------------
    logic [CLEAR_WID-1:0][IDX_W-1:0] head_id;
    logic [CLEAR_WID-1:0]            clr_lane;
    logic                            run;
    logic [CNT_W-1:0]                clear_num;

    for (genvar k = 0; k < CLEAR_WID; k++) begin : g_head_lane
        circ_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_head_add (
            .i_ptr (head_q),
            .i_off ((IDX_W+1)'(k)),
            .o_sum (head_id[k])
        );
    end

    // Lane k releases only if every older lane also releases.
    always_comb begin
        run      = 1'b1;
        clr_lane = '0;
        for (int k = 0; k < CLEAR_WID; k++) begin
            run         = run & valid_q[head_id[k]] & done_q[head_id[k]];
            clr_lane[k] = run;
        end
    end

    assign clear_num = CNT_W'(count_one(64'(clr_lane)));

    // ---------------- pointer advances ----------------
    logic [IDX_W-1:0] head_adv, tail_adv, sq_tail;
    logic [IDX_W:0]   sq_dist;

    circ_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_head_adv (
        .i_ptr (head_q), .i_off ((IDX_W+1)'(clear_num)), .o_sum (head_adv)
    );
    circ_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_tail_adv (
        .i_ptr (tail_q), .i_off ((IDX_W+1)'(enq_num)), .o_sum (tail_adv)
    );
    circ_ptr_add #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sq_tail (
        .i_ptr (sq_idx), .i_off ((IDX_W+1)'(1)), .o_sum (sq_tail)
    );

    assign sq_dist = age_of(sq_idx, head_q);

    // ---------------- next state ----------------
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_adv;
        tail_d  = tail_q;
        count_d = count_q - clear_num;

        for (int w = 0; w < WBPORT_NUM; w++) begin
            if (i_wb_vld[w] && ({1'b0, i_wb_dqIdx[w]} < DEPTH_X) && valid_q[i_wb_dqIdx[w]]) begin
                done_d[i_wb_dqIdx[w]] = 1'b1;
            end
        end

        // Releases win over a same-cycle writeback to the same slot.
        for (int k = 0; k < CLEAR_WID; k++) begin
            if (clr_lane[k]) begin
                valid_d[head_id[k]] = 1'b0;
                done_d[head_id[k]]  = 1'b0;
            end
        end

        if (sq.vld) begin
            if (sq.all) begin
                valid_d = '0;
                done_d  = '0;
                tail_d  = head_adv;
                count_d = '0;
            end else begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (age_of(IDX_W'(e), head_q) > sq_dist) begin
                        valid_d[e] = 1'b0;
                        done_d[e]  = 1'b0;
                    end
                end
                tail_d  = sq_tail;
                count_d = CNT_W'(sq_dist + (IDX_W+1)'(1)) - clear_num;
            end
        end else if (enq_fire) begin
            for (int i = 0; i < INPORT_NUM; i++) begin
                if (i_enq_req[i]) begin
                    valid_d[lane_id[i]] = 1'b1;
                    done_d[lane_id[i]]  = 1'b0;
                end
            end
            tail_d  = tail_adv;
            count_d = count_q + enq_num - clear_num;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < INPORT_NUM; i++) begin
                if (i_enq_req[i]) begin
                    mem_q[lane_id[i]] <= i_enq_data[i];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < READPORT_NUM; p++) begin
            o_read_data[p] = ({1'b0, i_read_dqIdx[p]} < DEPTH_X) ? mem_q[i_read_dqIdx[p]] : '0;
        end
    end

    // A partial squash must name a live entry.
    sq_idx_legal: assert property (@(posedge clk) disable iff (!rst)
        (sq.vld && !sq.all) |-> (({1'b0, sq_idx} < DEPTH_X) && valid_q[sq_idx]));

endmodule
